// File: rtl/cube_wireframe_raster_if.sv
// rtl/cube_wireframe_raster_if.sv - pixel stream between rasterizer and framebuffer writer
interface cube_wireframe_raster_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] pix_color;

  modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface

// File: rtl/cube_wireframe_raster.sv
// rtl/cube_wireframe_raster.sv - Bresenham walk of the 12 projected cube edges, one pixel per cycle
// Optional RASTER_CLIP_EN: off-screen pixels are suppressed instead of wrapped.
module cube_wireframe_raster #(
  parameter int FRAC_BITS = 8,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic signed [31:0]      i_verts [8][3],
  input  logic [7:0]              i_color,
  cube_wireframe_raster_if.master o_pix,
  output logic                    o_busy,
  output logic                    o_done
);

`ifdef RASTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t             r_state;
  logic signed [31:0] r_vx [8];
  logic signed [31:0] r_vy [8];
  logic [3:0]         r_e;
  logic signed [31:0] r_x, r_y, r_x1, r_y1, r_dx, r_dy, r_sx, r_sy, r_err;
  logic               r_valid;
  logic [9:0]         r_px;
  logic [8:0]         r_py;
  logic [7:0]         r_color;
  logic               r_busy;
  logic               r_done;

  logic [2:0]         w_va, w_vb;
  logic signed [31:0] w_x0, w_y0, w_x1, w_y1, w_dx, w_dy;
  logic signed [31:0] w_e2, w_x_nxt, w_y_nxt, w_err_nxt;
  logic               w_step_x, w_step_y, w_at_end, w_advance;

  // Edge e connects w_va (start point) to w_vb
  always_comb begin
    w_va = 3'd0;
    w_vb = 3'd1;
    case (r_e)
      4'd0:    begin w_va = 3'd0; w_vb = 3'd1; end
      4'd1:    begin w_va = 3'd1; w_vb = 3'd3; end
      4'd2:    begin w_va = 3'd3; w_vb = 3'd2; end
      4'd3:    begin w_va = 3'd2; w_vb = 3'd0; end
      4'd4:    begin w_va = 3'd4; w_vb = 3'd5; end
      4'd5:    begin w_va = 3'd5; w_vb = 3'd7; end
      4'd6:    begin w_va = 3'd7; w_vb = 3'd6; end
      4'd7:    begin w_va = 3'd6; w_vb = 3'd4; end
      4'd8:    begin w_va = 3'd0; w_vb = 3'd4; end
      4'd9:    begin w_va = 3'd1; w_vb = 3'd5; end
      4'd10:   begin w_va = 3'd2; w_vb = 3'd6; end
      4'd11:   begin w_va = 3'd3; w_vb = 3'd7; end
      default: begin w_va = 3'd0; w_vb = 3'd1; end
    endcase
  end

  assign w_x0 = r_vx[w_va];
  assign w_y0 = r_vy[w_va];
  assign w_x1 = r_vx[w_vb];
  assign w_y1 = r_vy[w_vb];
  assign w_dx = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
  assign w_dy = (w_y1 >= w_y0) ? (w_y0 - w_y1) : (w_y1 - w_y0);

  assign w_e2      = r_err <<< 1;
  assign w_step_x  = (w_e2 >= r_dy);
  assign w_step_y  = (w_e2 <= r_dx);
  assign w_x_nxt   = w_step_x ? (r_x + r_sx) : r_x;
  assign w_y_nxt   = w_step_y ? (r_y + r_sy) : r_y;
  assign w_err_nxt = r_err + (w_step_x ? r_dy : 32'sd0) + (w_step_y ? r_dx : 32'sd0);
  assign w_at_end  = (r_x == r_x1) && (r_y == r_y1);
  // A suppressed pixel (valid low while drawing) still consumes its step
  assign w_advance = !r_valid || o_pix.pix_ready;

  function automatic logic visible(input logic signed [31:0] x, input logic signed [31:0] y);
    return !CLIP_EN || ((x >= 0) && (x < SCREEN_W) && (y >= 0) && (y < SCREEN_H));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_e     <= 4'd0;
      r_valid <= 1'b0;
      r_px    <= 10'd0;
      r_py    <= 9'd0;
      r_color <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_err   <= '0;
      for (int k = 0; k < 8; k++) begin
        r_vx[k] <= '0;
        r_vy[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int k = 0; k < 8; k++) begin
              r_vx[k] <= i_verts[k][0] >>> FRAC_BITS;
              r_vy[k] <= i_verts[k][1] >>> FRAC_BITS;
            end
            r_color <= i_color;
            r_e     <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_x     <= w_x0;
          r_y     <= w_y0;
          r_x1    <= w_x1;
          r_y1    <= w_y1;
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_sx    <= (w_x1 >= w_x0) ? 32'sd1 : -32'sd1;
          r_sy    <= (w_y1 >= w_y0) ? 32'sd1 : -32'sd1;
          r_err   <= w_dx + w_dy;
          r_valid <= visible(w_x0, w_y0);
          r_px    <= w_x0[9:0];
          r_py    <= w_y0[8:0];
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (w_advance) begin
            if (w_at_end) begin
              r_valid <= 1'b0;
              if (r_e == 4'd11) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_e     <= r_e + 4'd1;
                r_state <= S_SETUP;
              end
            end else begin
              r_x     <= w_x_nxt;
              r_y     <= w_y_nxt;
              r_err   <= w_err_nxt;
              r_valid <= visible(w_x_nxt, w_y_nxt);
              r_px    <= w_x_nxt[9:0];
              r_py    <= w_y_nxt[8:0];
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_e     <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pix.pix_valid = r_valid;
  assign o_pix.pix_x     = r_px;
  assign o_pix.pix_y     = r_py;
  assign o_pix.pix_color = r_color;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: doc/cube_wireframe_raster.md
# cube_wireframe_raster

Wireframe line rasterizer directly downstream of the cube projection stage. Takes the 8 projected screen-space cube vertices (signed fixed point, 8 fractional bits) and walks the 12 cube edges with Bresenham, streaming one integer pixel coordinate per cycle to the framebuffer writer over a valid/ready handshake. One start command draws one whole cube.

## Interface
- FRAC_BITS, 8: fractional bits of the incoming vertex coordinates.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  draw request; sampled only in IDLE.
- verts  in  int [8][3]  vertex x/y/z, order: back_top_left, back_top_right, back_bot_left, back_bot_right, front_top_left, front_top_right, front_bot_left, front_bot_right (indices 0–7); z is ignored.
- color  in  8  pixel color, latched with verts.
- pix_valid  out  1  pix_x/pix_y/pix_color hold a pixel.
- pix_ready  in  1  consumer accepts pixel.
- pix_x  out  10  pixel column.
- pix_y  out  9  pixel row.
- pix_color  out  8  latched color.
- busy  out  1  high from cycle after accepted start until DONE.
- done  out  1  one-cycle pulse when last edge finishes.

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE: on start=1 latch verts (x,y only) and color, edge index e=0, go SETUP. start is ignored in every other state.
- Integer conversion: coord >>> FRAC_BITS (arithmetic shift, floor). 25728 → 100; -128 → -1.
- Edge order e=0..11: 0-1, 1-3, 3-2, 2-0, 4-5, 5-7, 7-6, 6-4, 0-4, 1-5, 2-6, 3-7. First listed vertex is the start point.
- SETUP (1 cycle): x=x0, y=y0, dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1 toward endpoint, err=dx+dy; go DRAW. Internal arithmetic 32-bit signed.
- DRAW, per step: present (x,y). Step advances when pixel is transferred (pix_valid & pix_ready) or suppressed. On advance: if (x,y)==(x1,y1) edge ends; else e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}.
- Edge end: if e==11 go DONE, else e++ and go SETUP.
- Both endpoints of every edge are emitted; shared vertices appear multiple times. Degenerate edge (x0,y0)==(x1,y1) emits exactly one pixel.
- DONE: done=1 for one cycle, busy=0, go IDLE.
- Reset (any time, including mid-edge): state=IDLE, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0, done=0, e=0. Partial cube is abandoned.

## Timing
- start accepted in cycle 0 → SETUP cycle 1 → first pix_valid cycle 2.
- Unstalled, in-range: one pixel per cycle within an edge; one bubble cycle (SETUP, pix_valid=0) between edges.
- pix_valid is registered; while pix_valid=1 and pix_ready=0, pix_x/pix_y/pix_color hold stable and pix_valid stays 1.
- done asserts the cycle after the final pixel transfer; busy falls in the same cycle.
- Earliest next start: the cycle after done (in IDLE).

## Configuration
- RASTER_CLIP_EN defined: pixels with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H are suppressed; they cost one cycle with pix_valid=0 and stepping continues.
- RASTER_CLIP_EN undefined: every pixel is emitted; pix_x/pix_y carry the low 10/9 bits of the coordinate (wraps). Consumer must not rely on in-range values.

## Test plan
- Axis-aligned square, x∈{100,110}, y∈{50,60}, front=back (×256), pix_ready=1 → 92 pixels (8 edges × 11 + 4 single-pixel connectors), first pixel (100,50) at cycle 2, done one cycle after last transfer.
- All vertices at (5,5) → exactly 12 pixels, all (5,5), 11 bubble cycles between them, one done pulse.
- Same square, pix_ready toggling 1,0,1,0 → identical 92-pixel sequence; outputs stable across every stall cycle.
- RASTER_CLIP_EN defined, edge 0 from x=-3 to x=3 at y=10 → pixels x=0..3 only, plus 3 suppressed cycles; undefined → 7 pixels with x=-3..-1 as 1021..1023.
- Reset asserted mid-DRAW of edge 5 → pix_valid, busy, done low immediately; start after release draws from edge 0.
- start pulsed while busy → ignored, pixel count unchanged; vertex x=25728 and -128 convert to 100 and -1.
